// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: decoder states, error codes and default sync marker shared by uart_frame_rx
package uart_frame_pkg;
  typedef enum logic [2:0] {IDLE, LEN, PAY, CHK, DRAIN} state_t;
  localparam logic [1:0] ERR_LEN = 2'b00;
  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_GAP = 2'b10;
  localparam logic [1:0] ERR_OVR = 2'b11;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload store, synchronous write and combinational read
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: SYNC/LEN/payload/CHK frame decoder releasing only checked payloads; frame stats built under UART_FRAME_STATS_EN
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int          MAX_LEN   = 16,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        rx_idle,
  output logic        pl_valid,
  output logic [7:0]  pl_data,
  output logic        pl_last,
  input  logic        pl_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);
  state_t        r_state;
  logic [LW-1:0] r_len, r_idx;
  logic [7:0]    r_sum;
  logic          r_pl_valid, r_frame_ok, r_frame_err;
  logic [1:0]    r_err_code;
  logic [7:0]    w_rdata, w_sum;
  logic          w_last, w_len_bad, w_gap;
  assign w_sum     = r_sum + byte_data;
  assign w_last    = r_idx == r_len - LW'(1);
  assign w_len_bad = byte_data == 8'd0 || int'(byte_data) > MAX_LEN;
  assign w_gap     = rx_idle && !byte_valid && r_state inside {LEN, PAY, CHK};
  uart_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk     (clk),
    .i_we    (byte_valid && r_state == PAY),
    .i_waddr (r_idx[AW-1:0]),
    .i_wdata (byte_data),
    .i_raddr (r_idx[AW-1:0]),
    .o_rdata (w_rdata)
  );
  // r_idx is the write pointer while filling and the read pointer while draining
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_pl_valid  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_gap) begin
        r_frame_err <= 1'b1;
        r_err_code  <= ERR_GAP;
        r_state     <= IDLE;
      end else
        case (r_state)
          IDLE: if (byte_valid && byte_data == SYNC_BYTE) r_state <= LEN;
          LEN: if (byte_valid) begin
            if (w_len_bad) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_LEN;
              r_state     <= IDLE;
            end else begin
              r_len   <= LW'(byte_data);
              r_sum   <= byte_data;
              r_idx   <= '0;
              r_state <= PAY;
            end
          end
          PAY: if (byte_valid) begin
            r_sum   <= w_sum;
            r_idx   <= r_idx + LW'(1);
            r_state <= w_last ? CHK : PAY;
          end
          CHK: if (byte_valid) begin
            if (w_sum == 8'd0) begin
              r_frame_ok <= 1'b1;
              r_pl_valid <= 1'b1;
              r_idx      <= '0;
              r_state    <= DRAIN;
            end else begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_CHK;
              r_state     <= IDLE;
            end
          end
          DRAIN: begin
            if (byte_valid) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_OVR;
            end
            if (r_pl_valid && pl_ready) begin
              r_idx      <= w_last ? '0 : r_idx + LW'(1);
              r_pl_valid <= !w_last;
              r_state    <= w_last ? IDLE : DRAIN;
            end
          end
          default: r_state <= IDLE;
        endcase
    end
  assign pl_valid  = r_pl_valid;
  assign pl_data   = r_pl_valid ? w_rdata : 8'h00;
  assign pl_last   = r_pl_valid && w_last;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
`ifdef UART_FRAME_STATS_EN
  logic [15:0] r_good_cnt, r_bad_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      if (r_frame_ok && r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 16'd1;
      if (r_frame_err && r_bad_cnt != 16'hFFFF) r_bad_cnt <= r_bad_cnt + 16'd1;
    end
  assign good_cnt = r_good_cnt;
  assign bad_cnt  = r_bad_cnt;
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif
endmodule
